// File: rtl/shift_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_issue_stage                                            |
// | Description : Registered issue stage feeding the RV64 shift unit; decodes  |
// |               shift instructions and buffers them in a 2-entry skid FIFO.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module shift_issue_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_alt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_A,
   output logic [XLEN-1:0] out_B,
   output logic [XLEN-1:0] out_C,
   output logic [1:0]      out_ShiftFn,
   output logic            out_ExtWord,
   output logic            out_illegal
);

   localparam logic [6:0] C_OP_IMM    = 7'b0010011;
   localparam logic [6:0] C_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] C_OP        = 7'b0110011;
   localparam logic [6:0] C_OP_32     = 7'b0111011;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] c;
      logic [1:0]      shiftFn;
      logic            extWord;
      logic            illegal;
   } entry_t;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_isImm;
   logic       w_isImm32;
   logic       w_isReg;
   logic       w_isShift;
   logic       w_funct7Ok;
   logic       w_illegal;
   logic [1:0] w_rawFn;
   entry_t     w_newEntry;
   logic       w_unusedFields;

   assign w_opcode       = in_instr[6:0];
   assign w_funct3       = in_instr[14:12];
   assign w_funct7       = in_instr[31:25];
   assign w_unusedFields = ^{in_instr[19:15], in_instr[11:7]};

   assign w_isImm    = (w_opcode == C_OP_IMM);
   assign w_isImm32  = (w_opcode == C_OP_IMM_32);
   assign w_isReg    = (w_opcode == C_OP) || (w_opcode == C_OP_32);
   assign w_isShift  = (w_isImm || w_isImm32 || w_isReg) &&
                       ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));
   assign w_funct7Ok = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);

   always_comb begin
      w_rawFn = 2'b00;
      if (w_isShift) begin
         w_rawFn = (w_funct3 == 3'b001) ? 2'b01 : (in_instr[30] ? 2'b11 : 2'b10);
      end
   end

   // Only the shamt field width differs between the immediate forms
   always_comb begin
      w_illegal = 1'b0;
      if (w_isShift) begin
         if (w_isImm) begin
            w_illegal = (in_instr[31:26] != 6'b000000) && (in_instr[31:26] != 6'b010000);
         end else if (w_isImm32) begin
            w_illegal = in_instr[25] || !w_funct7Ok;
         end else begin
            w_illegal = !w_funct7Ok;
         end
      end
   end

   always_comb begin
      w_newEntry.a       = in_rs1;
      w_newEntry.c       = in_alt;
      w_newEntry.b       = in_rs2;
      w_newEntry.extWord = w_isImm32 || (w_opcode == C_OP_32);
      w_newEntry.illegal = w_illegal;
      w_newEntry.shiftFn = w_illegal ? 2'b00 : w_rawFn;
      if (w_isShift && w_isImm) begin
         w_newEntry.b = {{(XLEN-6){1'b0}}, in_instr[25:20]};
      end else if (w_isShift && w_isImm32) begin
         w_newEntry.b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
      end
   end

   entry_t r_out;
   entry_t r_skid;
   logic   r_outValid;
   logic   r_skidValid;
   logic   r_inReady;

   logic w_accept;
   logic w_pop;
   logic w_outValidNext;
   logic w_skidValidNext;
   logic w_loadOutNew;
   logic w_loadOutSkid;
   logic w_loadSkid;

   assign w_accept = in_valid && r_inReady;
   assign w_pop    = r_outValid && out_ready;

   // SKID is only drained into OUT, so order is preserved; accept is never
   // possible while SKID is full because in_ready is low then.
   always_comb begin
      w_outValidNext  = r_outValid;
      w_skidValidNext = r_skidValid;
      w_loadOutNew    = 1'b0;
      w_loadOutSkid   = 1'b0;
      w_loadSkid      = 1'b0;
      if (!r_outValid || w_pop) begin
         if (r_skidValid) begin
            w_loadOutSkid   = 1'b1;
            w_outValidNext  = 1'b1;
            w_skidValidNext = 1'b0;
         end else if (w_accept) begin
            w_loadOutNew   = 1'b1;
            w_outValidNext = 1'b1;
         end else begin
            w_outValidNext = 1'b0;
         end
      end else if (w_accept) begin
         w_loadSkid      = 1'b1;
         w_skidValidNext = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out       <= '0;
         r_skid      <= '0;
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
         r_inReady   <= 1'b1;
      end else if (flush) begin
         r_outValid  <= 1'b0;
         r_skidValid <= 1'b0;
         r_inReady   <= 1'b1;
      end else begin
         r_outValid  <= w_outValidNext;
         r_skidValid <= w_skidValidNext;
         r_inReady   <= !w_skidValidNext;
         if (w_loadOutNew) begin
            r_out <= w_newEntry;
         end else if (w_loadOutSkid) begin
            r_out <= r_skid;
         end
         if (w_loadSkid) begin
            r_skid <= w_newEntry;
         end
      end
   end

   assign in_ready    = r_inReady;
   assign out_valid   = r_outValid;
   assign out_A       = r_out.a;
   assign out_B       = r_out.b;
   assign out_C       = r_out.c;
   assign out_ShiftFn = r_out.shiftFn;
   assign out_ExtWord = r_out.extWord;
   assign out_illegal = r_out.illegal;

endmodule
`default_nettype wire
